buttons_reader: RTL and testbench

// Input-side counterpart of the LED drivers: reads the board pushbuttons/switches,

---
 rtl/buttons_reader.sv | 100 ++++++++++
 tb/tb_buttons_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buttons_reader.sv
// Pushbutton front end: two-stage synchroniser, per-bit debounce, press/release events,
// sticky press flags with clear handshake, and an 8-bit press counter.
module buttons_reader #(
   parameter int unsigned N          = 2,
   parameter int unsigned DEBOUNCE   = 120000,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] sw,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   // named 'released' because 'release' is a reserved word
   output logic [N-1:0] released,
   output logic [N-1:0] flag,
   input  logic [N-1:0] flag_clr,
   output logic [7:0]   count,
   input  logic         count_clr
);

   localparam int unsigned   CW   = $clog2(DEBOUNCE) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

   logic [N-1:0]  pin;
   logic [N-1:0]  sync1;
   logic [N-1:0]  s;
   logic [CW-1:0] cnt      [N];
   logic [CW-1:0] cnt_next [N];
   logic [N-1:0]  level_next;
   logic [N-1:0]  press_next;
   logic [N-1:0]  release_next;
   logic [N-1:0]  flag_next;
   logic [7:0]    n_press;
   logic [7:0]    count_next;

   assign pin = ACTIVE_LOW ? ~sw : sw;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= '0;
         s     <= '0;
      end else begin
         sync1 <= pin;
         s     <= sync1;
      end
   end

   // Any cycle of agreement with the current level restarts the count.
   always_comb begin
      level_next   = level;
      press_next   = '0;
      release_next = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cnt_next[i] = '0;
         if (s[i] != level[i]) begin
            if (cnt[i] == LAST) begin
               level_next[i]   = s[i];
               press_next[i]   = s[i];
               release_next[i] = ~s[i];
            end else begin
               cnt_next[i] = cnt[i] + CW'(1);
            end
         end
      end
   end

   always_comb begin
      n_press = '0;
      for (int unsigned i = 0; i < N; i++) begin
         n_press = n_press + 8'(press_next[i]);
      end
   end

   // A press landing on the same edge as a clear request keeps the flag set.
   assign flag_next  = (flag & ~flag_clr) | press_next;
   assign count_next = (count_clr ? 8'h00 : count) + n_press;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < N; i++) begin
            cnt[i] <= '0;
         end
         level    <= '0;
         press    <= '0;
         released <= '0;
         flag     <= '0;
         count    <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            cnt[i] <= cnt_next[i];
         end
         level    <= level_next;
         press    <= press_next;
         released <= release_next;
         flag     <= flag_next;
         count    <= count_next;
      end
   end

endmodule

// File: tb/tb_buttons_reader.sv
// Scoreboarded bench for buttons_reader (N=2, DEBOUNCE=4): stimulus queues expected
// press/release events with their cycle stamps; a monitor checks each event as it appears.
module tb_buttons_reader;

   localparam int unsigned N  = 2;
   localparam int unsigned DB = 4;

   logic       clk       = 1'b0;
   logic       rstn      = 1'b0;
   logic [1:0] sw        = 2'b00;
   logic [1:0] flag_clr  = 2'b00;
   logic       count_clr = 1'b0;
   logic [1:0] level;
   logic [1:0] press;
   logic [1:0] rel;
   logic [1:0] flag;
   logic [7:0] count;

   int unsigned cyc         = 0;
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   typedef struct {
      int unsigned cyc;
      logic [1:0]  press;
      logic [1:0]  rel;
      logic [1:0]  level;
      logic [1:0]  flag;
      logic [7:0]  count;
   } ev_t;

   ev_t        q[$];
   logic [7:0] exp_count = 8'h00;
   logic [1:0] exp_flag  = 2'b00;

   buttons_reader #(
      .N(N),
      .DEBOUNCE(DB),
      .ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .sw(sw),
      .level(level),
      .press(press),
      .released(rel),
      .flag(flag),
      .flag_clr(flag_clr),
      .count(count),
      .count_clr(count_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every press/release pulse must match the head of the queue, on time.
   initial begin
      ev_t e;
      forever begin
         @(posedge clk);
         #1;
         while (q.size() > 0 && q[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missed_event: nothing at cycle %0d, required press=%b release=%b count=%h",
                     q[0].cyc, q[0].press, q[0].rel, q[0].count);
            void'(q.pop_front());
         end
         if ((press | rel) != 2'b00) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_event at cycle %0d: press=%b release=%b level=%b, required none",
                        cyc, press, rel, level);
            end else begin
               e = q.pop_front();
               if (e.cyc != cyc || e.press !== press || e.rel !== rel || e.level !== level ||
                   e.flag !== flag || e.count !== count) begin
                  miscompares++;
                  $display("FAIL event: got cyc=%0d press=%b release=%b level=%b flag=%b count=%h, required cyc=%0d press=%b release=%b level=%b flag=%b count=%h",
                           cyc, press, rel, level, flag, count,
                           e.cyc, e.press, e.rel, e.level, e.flag, e.count);
               end
            end
         end
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] expv);
      vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, got, expv);
      end
   endtask

   // Clean press of buttons b then release; optional count_clr on the edge the level rises.
   task automatic btn(input logic [1:0] b, input bit with_cclr);
      int unsigned m;
      m = cyc;
      sw = b;
      exp_count = (with_cclr ? 8'h00 : exp_count) + 8'(b[0]) + 8'(b[1]);
      exp_flag  = exp_flag | b;
      q.push_back(ev_t'{m + 6, b, 2'b00, b, exp_flag, exp_count});
      if (with_cclr) begin
         tick(5);
         count_clr = 1'b1;
         tick(1);
         count_clr = 1'b0;
         tick(2);
      end else begin
         tick(8);
      end
      m = cyc;
      sw = 2'b00;
      q.push_back(ev_t'{m + 6, 2'b00, b, 2'b00, exp_flag, exp_count});
      tick(8);
   endtask

   initial begin
      int unsigned m;
      bit bounce [6];
      bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      // Reset with both buttons held
      rstn = 1'b0;
      sw   = 2'b11;
      tick(3);
      chk("reset_level", {6'b0, level}, 8'h00);
      chk("reset_press", {6'b0, press}, 8'h00);
      chk("reset_release", {6'b0, rel}, 8'h00);
      chk("reset_flag", {6'b0, flag}, 8'h00);
      chk("reset_count", count, 8'h00);

      m = cyc;
      rstn = 1'b1;
      exp_count = 8'd2;
      exp_flag  = 2'b11;
      q.push_back(ev_t'{m + 6, 2'b11, 2'b00, 2'b11, 2'b11, 8'd2});
      tick(8);
      m = cyc;
      sw = 2'b00;
      q.push_back(ev_t'{m + 6, 2'b00, 2'b11, 2'b00, 2'b11, 8'd2});
      tick(8);

      flag_clr = 2'b11;
      tick(1);
      flag_clr = 2'b00;
      exp_flag = 2'b00;
      chk("flag_clear_both", {6'b0, flag}, 8'h00);

      // Glitch of 3 sampled cycles is rejected
      sw = 2'b01;
      tick(3);
      sw = 2'b00;
      tick(8);
      chk("glitch_level", {6'b0, level}, 8'h00);
      chk("glitch_count", count, exp_count);

      // Stable for 4+ cycles is accepted
      btn(2'b01, 1'b0);

      // Bounce 1,0,1,1,0,1 then steady 1: one press at 11 edges after first drive
      m = cyc;
      exp_count = exp_count + 8'd1;
      exp_flag  = exp_flag | 2'b01;
      q.push_back(ev_t'{m + 11, 2'b01, 2'b00, 2'b01, exp_flag, exp_count});
      for (int i = 0; i < 6; i++) begin
         sw = {1'b0, bounce[i]};
         tick(1);
      end
      sw = 2'b01;
      tick(12);
      m = cyc;
      sw = 2'b00;
      q.push_back(ev_t'{m + 6, 2'b00, 2'b01, 2'b00, exp_flag, exp_count});
      tick(8);

      // Flag handshake on button 1
      btn(2'b10, 1'b0);
      m = cyc;
      sw = 2'b10;
      exp_count = exp_count + 8'd1;
      q.push_back(ev_t'{m + 6, 2'b10, 2'b00, 2'b10, 2'b11, exp_count});
      tick(5);
      flag_clr = 2'b10;
      tick(1);
      flag_clr = 2'b00;
      chk("flag_set_wins", {6'b0, flag}, 8'h03);
      tick(1);
      chk("flag_after_set_wins", {6'b0, flag}, 8'h03);
      flag_clr = 2'b10;
      tick(1);
      flag_clr = 2'b00;
      exp_flag = 2'b01;
      chk("flag_clear_one", {6'b0, flag}, 8'h01);
      m = cyc;
      sw = 2'b00;
      q.push_back(ev_t'{m + 6, 2'b00, 2'b10, 2'b00, 2'b01, exp_count});
      tick(8);

      // Count up to 255, then wrap
      while (exp_count != 8'hFF) btn(2'b01, 1'b0);
      chk("count_ff", count, 8'hFF);
      btn(2'b01, 1'b0);
      chk("count_wrap", count, 8'h00);

      // count_clr coinciding with a press on both buttons
      btn(2'b11, 1'b1);
      chk("count_clr_press", count, 8'd2);

      // Async reset mid-debounce
      m = cyc;
      sw = 2'b01;
      tick(2);
      rstn = 1'b0;
      #2;
      chk("midreset_flag", {6'b0, flag}, 8'h00);
      chk("midreset_count", count, 8'h00);
      rstn = 1'b1;
      exp_count = 8'd1;
      exp_flag  = 2'b01;
      q.push_back(ev_t'{m + 8, 2'b01, 2'b00, 2'b01, 2'b01, 8'd1});
      tick(10);
      m = cyc;
      sw = 2'b00;
      q.push_back(ev_t'{m + 6, 2'b00, 2'b01, 2'b00, 2'b01, 8'd1});
      tick(10);

      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL pending_events: %0d left in queue, required 0", q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
